// File: rtl/word_to_dibit_serializer_pkg.sv
// Shared constants, state encoding and sizing helper for the conv32Bto2B serializer.
package conv_pkg;

   localparam int unsigned QPSK_SYM_W = 2;
   localparam int unsigned WORD_W     = 32;

   // State is the {act_valid, pend_valid} pair held in the top module.
   localparam logic [1:0] EMPTY  = 2'b00;
   localparam logic [1:0] ACTIVE = 2'b10;
   localparam logic [1:0] FULL   = 2'b11;

   function automatic int unsigned sym_per_word(input int unsigned data_w,
                                                input int unsigned sym_w);
      return data_w / sym_w;
   endfunction

endpackage

// File: rtl/word_to_dibit_serializer_sym_shift_reg.sv
// Active word shift register and symbol counter; presents one symbol at the emit end.
module sym_shift_reg
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W    = WORD_W,
   parameter int unsigned SYM_W     = QPSK_SYM_W,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_data,
   output logic [SYM_W-1:0]  cur_sym,
   output logic              is_last
);

   localparam int unsigned K     = sym_per_word(DATA_W, SYM_W);
   localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  sym_cnt;

   // Load takes priority; shifting moves the next symbol toward the emit end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg   <= '0;
         sym_cnt <= '0;
      end else if (load) begin
         shreg   <= load_data;
         sym_cnt <= '0;
      end else if (shift) begin
         if (MSB_FIRST) shreg <= shreg << SYM_W;
         else           shreg <= shreg >> SYM_W;
         sym_cnt <= sym_cnt + CNT_W'(1);
      end
   end

   assign cur_sym = MSB_FIRST ? shreg[DATA_W-1 -: SYM_W] : shreg[SYM_W-1:0];
   assign is_last = (sym_cnt == CNT_W'(K - 1));

endmodule

// File: rtl/word_to_dibit_serializer.sv
// Splits valid/ready words into SYM_W-bit symbols, one per handshake, with a one-word skid
// so consecutive words stream at one symbol per clock.
module word_to_dibit_serializer
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W    = WORD_W,
   parameter int unsigned SYM_W     = QPSK_SYM_W,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_tdata,
   input  logic              in_tvalid,
   output logic              in_tready,
   output logic [SYM_W-1:0]  out_tdata,
   output logic              out_tvalid,
   input  logic              out_tready,
   output logic              out_tlast
);

   logic              act_valid;
   logic              pend_valid;
   logic [DATA_W-1:0] pend;
   logic [1:0]        state;

   logic              sr_load;
   logic              sr_shift;
   logic [DATA_W-1:0] sr_data;
   logic              is_last;

   logic              sym_fire;
   logic              in_fire;
   logic              last_fire;

   assign state     = {act_valid, pend_valid};
   assign in_tready = !pend_valid;
   assign sym_fire  = act_valid && out_tready;
   assign in_fire   = in_tvalid && !pend_valid;
   assign last_fire = sym_fire && is_last;

   assign out_tvalid = act_valid;
   assign out_tlast  = act_valid && is_last;

   // Shift-register commands: refill on a new/pending word, otherwise step on each symbol.
   always_comb begin
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      sr_data  = in_tdata;
      case (state)
         EMPTY: sr_load = in_fire;
         ACTIVE: begin
            sr_load  = last_fire && in_fire;
            sr_shift = sym_fire && !last_fire;
         end
         FULL: begin
            sr_load  = last_fire;
            sr_data  = pend;
            sr_shift = sym_fire && !last_fire;
         end
         default: ;
      endcase
   end

   // Occupancy and pending-word control.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         act_valid  <= 1'b0;
         pend_valid <= 1'b0;
         pend       <= '0;
      end else begin
         case (state)
            EMPTY: if (in_fire) act_valid <= 1'b1;
            ACTIVE: begin
               if (last_fire && !in_fire) begin
                  act_valid <= 1'b0;
               end else if (!last_fire && in_fire) begin
                  pend       <= in_tdata;
                  pend_valid <= 1'b1;
               end
            end
            FULL: if (last_fire) pend_valid <= 1'b0;
            default: begin
               act_valid  <= 1'b0;
               pend_valid <= 1'b0;
            end
         endcase
      end
   end

   sym_shift_reg #(
      .DATA_W    (DATA_W),
      .SYM_W     (SYM_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_sym_shift_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (sr_load),
      .shift     (sr_shift),
      .load_data (sr_data),
      .cur_sym   (out_tdata),
      .is_last   (is_last)
   );

endmodule

// File: tb/tb_word_to_dibit_serializer.sv
// Drives three serializer variants (MSB/2b, LSB/2b, MSB/4b) from shared inputs against a symbol-queue model.
module tb_word_to_dibit_serializer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] in_tdata;
   logic        in_tvalid;
   logic        out_tready;

   logic        rdy0, rdy1, rdy2;
   logic [1:0]  dat0, dat1;
   logic [3:0]  dat2;
   logic        vld0, vld1, vld2;
   logic        lst0, lst1, lst2;

   int          tests = 0;
   int          fails = 0;

   string       nm    [3] = '{"msb2", "lsb2", "msb4"};
   int          sw_t  [3] = '{2, 2, 4};
   bit          msb_t [3] = '{1'b1, 1'b0, 1'b1};
   logic [4:0]  q     [3][$];

   always #5 clk = ~clk;

   word_to_dibit_serializer #(.DATA_W(32), .SYM_W(2), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(rdy0),
      .out_tdata(dat0), .out_tvalid(vld0), .out_tready(out_tready), .out_tlast(lst0));

   word_to_dibit_serializer #(.DATA_W(32), .SYM_W(2), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset_n(reset_n), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(rdy1),
      .out_tdata(dat1), .out_tvalid(vld1), .out_tready(out_tready), .out_tlast(lst1));

   word_to_dibit_serializer #(.DATA_W(32), .SYM_W(4), .MSB_FIRST(1'b1)) dut_w4 (
      .clk(clk), .reset_n(reset_n), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(rdy2),
      .out_tdata(dat2), .out_tvalid(vld2), .out_tready(out_tready), .out_tlast(lst2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Symbol i of word w, counted from whichever end is emitted first.
   function automatic logic [3:0] sym_of(input logic [31:0] w, input int sw, input bit msb, input int i);
      logic [31:0] sh;
      sh = msb ? (w >> (32 - sw * (i + 1))) : (w >> (sw * i));
      return 4'(sh & ((32'd1 << sw) - 32'd1));
   endfunction

   task automatic check_idle(input string tag);
      check({tag, ".msb2.tvalid"}, 32'(vld0), 32'd0);
      check({tag, ".msb2.tlast"},  32'(lst0), 32'd0);
      check({tag, ".msb2.tready"}, 32'(rdy0), 32'd1);
      check({tag, ".lsb2.tvalid"}, 32'(vld1), 32'd0);
      check({tag, ".msb4.tvalid"}, 32'(vld2), 32'd0);
      check({tag, ".msb4.tready"}, 32'(rdy2), 32'd1);
   endtask

   // One clock: drive inputs, compare every instance to the model, advance the model, clock.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r, output logic acc0);
      logic [3:0] o_d;
      logic       o_v, o_l, o_r, nonempty, exp_rdy;
      int         k, words;
      in_tvalid  = v;
      in_tdata   = d;
      out_tready = r;
      acc0       = 1'b0;
      for (int idx = 0; idx < 3; idx++) begin
         case (idx)
            0:       begin o_d = 4'(dat0); o_v = vld0; o_l = lst0; o_r = rdy0; end
            1:       begin o_d = 4'(dat1); o_v = vld1; o_l = lst1; o_r = rdy1; end
            default: begin o_d = dat2;     o_v = vld2; o_l = lst2; o_r = rdy2; end
         endcase
         k        = 32 / sw_t[idx];
         nonempty = (q[idx].size() != 0);
         words    = (q[idx].size() + k - 1) / k;
         exp_rdy  = (words < 2);
         check({nm[idx], ".tvalid"}, 32'(o_v), 32'(nonempty));
         check({nm[idx], ".tready"}, 32'(o_r), 32'(exp_rdy));
         if (nonempty) begin
            check({nm[idx], ".tdata"}, 32'(o_d), 32'(q[idx][0][3:0]));
            check({nm[idx], ".tlast"}, 32'(o_l), 32'(q[idx][0][4]));
            if (r) void'(q[idx].pop_front());
         end
         if (v && exp_rdy) begin
            for (int j = 0; j < k; j++)
               q[idx].push_back({(j == k - 1), sym_of(d, sw_t[idx], msb_t[idx], j)});
            if (idx == 0) acc0 = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      logic acc = 1'b0;
      for (int n = 0; n < 100 && !acc; n++) cycle(1'b1, w, 1'b1, acc);
      check("send_accepted", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      logic acc;
      for (int n = 0; n < 300 && (q[0].size() + q[1].size() + q[2].size()) != 0; n++)
         cycle(1'b0, 32'd0, 1'b1, acc);
      check("drain_empty", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
   endtask

   initial begin
      logic acc;
      reset_n    = 1'b0;
      in_tdata   = '0;
      in_tvalid  = 1'b0;
      out_tready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_idle("reset");
      check("reset.msb2.tdata", 32'(dat0), 32'd0);
      check("reset.msb4.tdata", 32'(dat2), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word: 3,2,1,0 x4 on msb2.
      send_word(32'hE4E4_E4E4);
      drain();

      // Back-to-back words with no bubble between them.
      send_word(32'hFFFF_FFFF);
      send_word(32'h0000_0000);
      drain();

      // Downstream stall after the first symbol is presented.
      send_word(32'h1B00_0000);
      for (int n = 0; n < 5; n++) cycle(1'b0, 32'd0, 1'b0, acc);
      drain();

      // LSB-first ordering on dut_lsb, nibble ordering on dut_w4.
      send_word(32'h0000_00E4);
      drain();
      send_word(32'h1234_5678);
      drain();

      // Reset with one word mid-emission and another pending.
      send_word(32'hAAAA_AAAA);
      cycle(1'b1, 32'h1234_5678, 1'b1, acc);
      for (int n = 0; n < 6; n++) cycle(1'b0, 32'd0, 1'b1, acc);
      check("midreset.pending", 32'(rdy0), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("midreset");
      for (int i = 0; i < 3; i++) q[i].delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      send_word(32'h5555_5555);
      drain();

      // Random traffic, including withdrawn in_tvalid and random stalls.
      for (int n = 0; n < 400; n++)
         cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0), acc);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/word_to_dibit_serializer.md
Name: word_to_dibit_serializer

Overview:
- Downstream stage of the 32-bit word repeater in the conv32Bto2B RFNoC block.
- Accepts 32-bit words over a valid/ready stream and emits them as 16 consecutive 2-bit QPSK symbols, MSB-first, one symbol per handshake.
- Holds one pending word so that back-to-back words stream without a bubble, giving a sustained rate of one symbol per clock.

Parameters:
- DATA_W, 32: input word width; must be an integer multiple of SYM_W.
- SYM_W, 2: symbol width in bits (2 = QPSK dibit).
- MSB_FIRST, 1: 1 = emit bits [DATA_W-1 -: SYM_W] first; 0 = emit bits [SYM_W-1:0] first.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_tdata  in  DATA_W  input word.
- in_tvalid  in  1  input word valid.
- in_tready  out  1  block can accept a word.
- out_tdata  out  SYM_W  current symbol.
- out_tvalid  out  1  symbol valid.
- out_tready  in  1  downstream accepts symbol.
- out_tlast  out  1  high on the last symbol of each word.

Behaviour:
- Derived constant: K = DATA_W/SYM_W (16 by default). sym_cnt is clog2(K) bits wide and counts 0..K-1.
- Storage:
  - Active shift register shreg plus act_valid.
  - One-entry pending register pend plus pend_valid.
- in_tready = !pend_valid. It depends on register state only, with no combinational path from out_tready.
- Reset (reset_n low, asynchronous):
  - act_valid=0, pend_valid=0, sym_cnt=0, shreg=0, pend=0.
  - Outputs: out_tvalid=0, out_tlast=0, out_tdata=0, in_tready=1.
  - Asserting reset mid-word discards the active and pending words. There is no partial output after release.
- Output mapping:
  - out_tvalid = act_valid.
  - out_tdata = top SYM_W bits of shreg (MSB_FIRST=1) or bottom SYM_W bits (MSB_FIRST=0).
  - out_tlast = act_valid && sym_cnt==K-1.
- Define sym_fire = out_tvalid && out_tready, in_fire = in_tvalid && in_tready, and last_fire = sym_fire && sym_cnt==K-1.
- States (encoded by act_valid/pend_valid): EMPTY (0/0), ACTIVE (1/0), FULL (1/1).
- EMPTY:
  - in_fire loads shreg from in_tdata, sets sym_cnt=0, moves to ACTIVE.
  - Latency: a word accepted at edge t presents its first symbol valid after edge t.
- ACTIVE:
  - sym_fire && !last_fire shifts shreg by SYM_W toward the emit side and increments sym_cnt.
  - last_fire && in_fire loads shreg from in_tdata and sets sym_cnt=0; stays ACTIVE with no bubble.
  - last_fire && !in_fire moves to EMPTY.
  - !last_fire && in_fire captures the word into pend and moves to FULL.
- FULL:
  - in_tready=0.
  - Shifts on sym_fire as in ACTIVE.
  - last_fire loads shreg from pend, sets sym_cnt=0, clears pend_valid, moves to ACTIVE.
- Backpressure:
  - While out_tready=0, shreg, sym_cnt and all outputs hold stable.
  - out_tvalid never drops without a handshake.
- Upstream compatibility: in_tvalid may be withdrawn without a handshake (the upstream repeater does this); no state change results.
- Words are never reordered, dropped or duplicated. Exactly K symbols are emitted per accepted word.

Decomposition:
- Shared package conv_pkg:
  - Constants QPSK_SYM_W=2 and WORD_W=32.
  - Function sym_per_word(DATA_W, SYM_W).
  - State encoding localparams EMPTY/ACTIVE/FULL.
- One natural sub-module: sym_shift_reg, holding shreg plus sym_cnt. It provides load, shift, cur_sym and is_last.
- Handshake and pending-register control stay in the top module.

Test Plan:
- Single word 0xE4E4E4E4, MSB_FIRST=1, out_tready=1:
  - out_tdata is 3,2,1,0 repeated 4 times over 16 consecutive cycles.
  - out_tlast is high only on the 16th symbol.
  - in_tready stays high.
- Two words 0xFFFFFFFF then 0x00000000 presented back-to-back, out_tready=1:
  - Produces 16 symbols of 3 followed by 16 symbols of 0 with no gap.
  - in_tready drops to 0 from the cycle after the second word is accepted until the first word's last symbol fires.
- Backpressure, word 0x1B000000:
  - Deassert out_tready for 5 cycles after the first symbol (0) is presented.
  - out_tdata stays 0 and out_tvalid stays 1 throughout.
  - After release the sequence continues 0,1,2,3,0,... with 16 symbols total.
- MSB_FIRST=0, word 0x000000E4: first four symbols are 0,1,2,3, then 12 zeros.
- Reset mid-word:
  - Pull reset_n low after 7 symbols of 0xAAAAAAAA with a second word pending.
  - Immediately: out_tvalid=0, in_tready=1, out_tlast=0.
  - After release, a new word 0x55555555 yields exactly 16 symbols of 1.
- Parameter sweep DATA_W=32, SYM_W=4, word 0x12345678: 8 symbols 1..8 are emitted, with out_tlast on the 8th.
